grey_threshold: RTL and testbench

//  Downstream of the greyscale stage: consumes 8-bit luma + hsync/vsync/VDE, emits 24-bit binarised RGB for the video out.

---
 rtl/grey_threshold.sv | 178 +++++++++++++++++
 tb/tb_grey_threshold.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/grey_threshold.sv
// Luma binariser: 2-stage video pipeline with manual or frame-mean threshold.
// Optional GREY_THRESH_INVERT_EN adds btn[3] inversion of the binary output.
module grey_threshold #(
    parameter int SUM_W         = 32,
    parameter int CNT_W         = 24,
    parameter int MANUAL_THRESH = 128,
    parameter bit VSYNC_POL     = 1'b1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  i_vid_data,
    input  logic        i_vid_hsync,
    input  logic        i_vid_vsync,
    input  logic        i_vid_VDE,
    input  logic [3:0]  btn,
    output logic [23:0] o_vid_data,
    output logic        o_vid_hsync,
    output logic        o_vid_vsync,
    output logic        o_vid_VDE,
    output logic [7:0]  o_threshold
);

    localparam logic [7:0] MAN_T = 8'(MANUAL_THRESH);
    localparam int         BCW   = $clog2(SUM_W + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_UPDATE} state_t;

    logic [7:0]       r_s1_data;
    logic             r_s1_hsync;
    logic             r_s1_vsync;
    logic             r_s1_vde;
    logic             r_vs_prev;

    logic [SUM_W-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;

    state_t           r_state;
    logic [SUM_W-1:0] r_dividend;
    logic [CNT_W-1:0] r_divisor;
    logic [CNT_W-1:0] r_rem;
    logic [SUM_W-1:0] r_quot;
    logic [BCW-1:0]   r_bit_cnt;
    logic [7:0]       r_threshold;

    logic             w_frame_end;
    logic [SUM_W:0]   w_sum_add;
    logic [CNT_W:0]   w_cnt_add;
    logic [CNT_W:0]   w_rem_shift;
    logic             w_fits;
    logic [CNT_W-1:0] w_rem_diff;
    logic [CNT_W-1:0] w_rem_next;
    logic [7:0]       w_thresh;
    logic             w_hit;
    logic             w_bin;
    logic [23:0]      w_rgb;
    logic             w_unused_btn;

    // Stage 1: register the incoming video.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_s1_data  <= '0;
            r_s1_hsync <= 1'b0;
            r_s1_vsync <= 1'b0;
            r_s1_vde   <= 1'b0;
            r_vs_prev  <= 1'b0;
        end else begin
            r_s1_data  <= i_vid_data;
            r_s1_hsync <= i_vid_hsync;
            r_s1_vsync <= i_vid_vsync;
            r_s1_vde   <= i_vid_VDE;
            r_vs_prev  <= r_s1_vsync;
        end
    end

    assign w_frame_end = VSYNC_POL ? (r_s1_vsync & ~r_vs_prev)
                                   : (~r_s1_vsync & r_vs_prev);

    assign w_sum_add = {1'b0, r_sum} + {{(SUM_W - 7){1'b0}}, r_s1_data};
    assign w_cnt_add = {1'b0, r_cnt} + (CNT_W + 1)'(1);

    // Frame statistics; a pixel on the frame-end cycle starts the new frame.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else if (w_frame_end) begin
            r_sum <= r_s1_vde ? {{(SUM_W - 8){1'b0}}, r_s1_data} : '0;
            r_cnt <= r_s1_vde ? CNT_W'(1) : '0;
        end else if (r_s1_vde) begin
            r_sum <= w_sum_add[SUM_W] ? {SUM_W{1'b1}} : w_sum_add[SUM_W-1:0];
            r_cnt <= w_cnt_add[CNT_W] ? {CNT_W{1'b1}} : w_cnt_add[CNT_W-1:0];
        end
    end

    // Restoring divider step: remainder stays below the divisor, so CNT_W bits hold it.
    assign w_rem_shift = {r_rem, r_dividend[SUM_W-1]};
    assign w_fits      = (w_rem_shift >= {1'b0, r_divisor});
    assign w_rem_diff  = CNT_W'(w_rem_shift - {1'b0, r_divisor});
    assign w_rem_next  = w_fits ? w_rem_diff : w_rem_shift[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state     <= ST_IDLE;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_bit_cnt   <= '0;
            r_threshold <= MAN_T;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_frame_end && (r_cnt != '0)) begin
                        r_dividend <= r_sum;
                        r_divisor  <= r_cnt;
                        r_rem      <= '0;
                        r_quot     <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    r_dividend <= {r_dividend[SUM_W-2:0], 1'b0};
                    r_rem      <= w_rem_next;
                    r_quot     <= {r_quot[SUM_W-2:0], w_fits};
                    if (r_bit_cnt == BCW'(SUM_W - 1)) begin
                        r_state <= ST_UPDATE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BCW'(1);
                    end
                end
                ST_UPDATE: begin
                    r_threshold <= (|r_quot[SUM_W-1:8]) ? 8'hFF : r_quot[7:0];
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_threshold = r_threshold;

    always_comb begin
        w_thresh = btn[2] ? r_threshold : MAN_T;
        w_hit    = (r_s1_data >= w_thresh);
`ifdef GREY_THRESH_INVERT_EN
        w_bin    = btn[3] ? ~w_hit : w_hit;
`else
        w_bin    = w_hit;
`endif
        w_rgb    = '0;
        if (r_s1_vde) begin
            w_rgb = btn[1] ? {24{w_bin}} : {r_s1_data, r_s1_data, r_s1_data};
        end
    end

`ifdef GREY_THRESH_INVERT_EN
    assign w_unused_btn = btn[0];
`else
    assign w_unused_btn = ^{btn[3], btn[0]};
`endif

    // Stage 2: registered outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            o_vid_data  <= '0;
            o_vid_hsync <= 1'b0;
            o_vid_vsync <= 1'b0;
            o_vid_VDE   <= 1'b0;
        end else begin
            o_vid_data  <= w_rgb;
            o_vid_hsync <= r_s1_hsync;
            o_vid_vsync <= r_s1_vsync;
            o_vid_VDE   <= r_s1_vde;
        end
    end

endmodule

// File: tb/tb_grey_threshold.sv
// Directed bench for grey_threshold: pipeline, manual/auto threshold, divider, inversion.
module tb_grey_threshold;

    logic        clk;
    logic        n_rst;
    logic [7:0]  i_vid_data;
    logic        i_vid_hsync;
    logic        i_vid_vsync;
    logic        i_vid_VDE;
    logic [3:0]  btn;
    logic [23:0] o_vid_data;
    logic        o_vid_hsync;
    logic        o_vid_vsync;
    logic        o_vid_VDE;
    logic [7:0]  o_threshold;

    int n_checks = 0;
    int n_fail   = 0;

    grey_threshold dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_vid_data  (i_vid_data),
        .i_vid_hsync (i_vid_hsync),
        .i_vid_vsync (i_vid_vsync),
        .i_vid_VDE   (i_vid_VDE),
        .btn         (btn),
        .o_vid_data  (o_vid_data),
        .o_vid_hsync (o_vid_hsync),
        .o_vid_vsync (o_vid_vsync),
        .o_vid_VDE   (o_vid_VDE),
        .o_threshold (o_threshold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of input, then step to 1 time unit past the edge.
    task automatic drive(input logic [7:0] y, input logic vde, input logic hs, input logic vs);
        i_vid_data  = y;
        i_vid_VDE   = vde;
        i_vid_hsync = hs;
        i_vid_vsync = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        btn   = 4'b0110;
        for (int i = 0; i < 3; i++) drive(8'hAB, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (o_vid_data !== 24'h0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 000000", o_vid_data);
        end
        n_checks++;
        if ({o_vid_hsync, o_vid_vsync, o_vid_VDE} !== 3'b000) begin
            n_fail++; $display("FAIL reset_syncs: got %b expected 000", {o_vid_hsync, o_vid_vsync, o_vid_VDE});
        end
        n_checks++;
        if (o_threshold !== 8'd128) begin
            n_fail++; $display("FAIL reset_threshold: got %0d expected 128", o_threshold);
        end
        n_rst = 1'b1;
        btn   = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            drive(8'h77, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (o_vid_data !== 24'h0 || o_vid_VDE !== 1'b0) begin
                n_fail++; $display("FAIL idle_vde0: got data %h vde %b expected 000000 0", o_vid_data, o_vid_VDE);
            end
        end
    endtask

    task automatic test_passthrough();
        btn = 4'b0000;
        drive(8'h5A, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (o_vid_VDE !== 1'b0 || o_vid_hsync !== 1'b0) begin
            n_fail++; $display("FAIL latency_early: got vde %b hs %b expected 0 0", o_vid_VDE, o_vid_hsync);
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (o_vid_data !== 24'h5A5A5A || o_vid_VDE !== 1'b1 || o_vid_hsync !== 1'b1) begin
            n_fail++; $display("FAIL passthrough: got %h vde %b hs %b expected 5a5a5a 1 1", o_vid_data, o_vid_VDE, o_vid_hsync);
        end
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_vid_data !== 24'h0 || o_vid_VDE !== 1'b0 || o_vid_vsync !== 1'b0) begin
            n_fail++; $display("FAIL pass_after: got %h vde %b vs %b expected 000000 0 0", o_vid_data, o_vid_VDE, o_vid_vsync);
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (o_vid_vsync !== 1'b1) begin
            n_fail++; $display("FAIL vsync_delay: got %b expected 1", o_vid_vsync);
        end
    endtask

    task automatic test_manual();
        logic [7:0]  ys  [4] = '{8'd127, 8'd128, 8'd0, 8'd255};
        logic [23:0] exps[4] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
        btn = 4'b0010;
        drive(ys[0], 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(ys[i+1], 1'b1, 1'b0, 1'b0);
            else       drive(8'h00, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (o_vid_data !== exps[i]) begin
                n_fail++; $display("FAIL manual_y%0d: got %h expected %h", ys[i], o_vid_data, exps[i]);
            end
        end
    endtask

    task automatic test_auto_mean();
        do_reset();
        btn = 4'b0000;
        for (int i = 0; i < 500; i++) drive(8'd40, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 500; i++) drive(8'd200, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(8'h00, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_threshold !== 8'd128) begin
            n_fail++; $display("FAIL thresh_mid_div: got %0d expected 128", o_threshold);
        end
        for (int i = 0; i < 40; i++) drive(8'h00, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_threshold !== 8'd120) begin
            n_fail++; $display("FAIL auto_mean: got %0d expected 120", o_threshold);
        end
        btn = 4'b0110;
        drive(8'd119, 1'b1, 1'b0, 1'b1);
        drive(8'd120, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (o_vid_data !== 24'h000000) begin
            n_fail++; $display("FAIL auto_y119: got %h expected 000000", o_vid_data);
        end
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_vid_data !== 24'hFFFFFF) begin
            n_fail++; $display("FAIL auto_y120: got %h expected ffffff", o_vid_data);
        end
    endtask

    task automatic test_frame_edges();
        // Previous frame held 119 and 120: mean 119.
        for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) drive(8'h00, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_threshold !== 8'd119) begin
            n_fail++; $display("FAIL two_px_mean: got %0d expected 119", o_threshold);
        end
        for (int i = 0; i < 5; i++) drive(8'h33, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) drive(8'h00, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_threshold !== 8'd119) begin
            n_fail++; $display("FAIL empty_frame: got %0d expected 119", o_threshold);
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(8'd60, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b0, 1'b1);
        drive(8'd250, 1'b1, 1'b0, 1'b0);
        drive(8'd250, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) drive(8'h00, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_threshold !== 8'd60) begin
            n_fail++; $display("FAIL edge_in_div: got %0d expected 60", o_threshold);
        end
        for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) drive(8'h00, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_threshold !== 8'd60) begin
            n_fail++; $display("FAIL discarded_frame: got %0d expected 60", o_threshold);
        end
    endtask

    task automatic test_invert();
        logic [23:0] exp_hi;
        logic [23:0] exp_lo;
`ifdef GREY_THRESH_INVERT_EN
        exp_hi = 24'h000000;
        exp_lo = 24'hFFFFFF;
`else
        exp_hi = 24'hFFFFFF;
        exp_lo = 24'h000000;
`endif
        btn = 4'b1010;
        drive(8'd200, 1'b1, 1'b0, 1'b1);
        drive(8'd10, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (o_vid_data !== exp_hi) begin
            n_fail++; $display("FAIL invert_y200: got %h expected %h", o_vid_data, exp_hi);
        end
        btn = 4'b1010;
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_vid_data !== exp_lo) begin
            n_fail++; $display("FAIL invert_y10: got %h expected %h", o_vid_data, exp_lo);
        end
        btn = 4'b1000;
        drive(8'h33, 1'b1, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_vid_data !== 24'h333333) begin
            n_fail++; $display("FAIL invert_pass: got %h expected 333333", o_vid_data);
        end
    endtask

    initial begin
        n_rst       = 1'b0;
        btn         = 4'b0000;
        i_vid_data  = 8'h00;
        i_vid_hsync = 1'b0;
        i_vid_vsync = 1'b0;
        i_vid_VDE   = 1'b0;
        test_reset();
        test_passthrough();
        test_manual();
        test_auto_mean();
        test_frame_edges();
        test_invert();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
